cm162_down_counter: RTL
=======================

Name: cm162_down_counter

Overview:
- Registered, cascadable down-counter slice; the opposite-direction counterpart of the team's combinational up-count/parallel-load slice (CM162).
- Loads a value, decrements once per enabled cycle while running, and signals terminal borrow for the next slice.
- Small FSM with start/done handshake so a controller can launch a countdown and wait for completion.
- Sits in the counter/timer datapath of the mapped benchmark suite; cascaded slices form wider timers.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- RESET_VAL, 0, count value after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value captured on load.
- start  input  1  begin countdown (handshake request).
- cnt_en  input  1  global count enable.
- borrow_in  input  1  cascade enable from the lower slice; tie 1 on the lowest slice.
- count  output  WIDTH  current registered count.
- borrow_out  output  1  combinational: count==0 & cnt_en & borrow_in & state==RUN.
- busy  output  1  registered, high in RUN.
- done  output  1  registered, one-cycle pulse on RUN->IDLE.

Behaviour:
- Reset (synchronous, active-high, checked first every edge): count=RESET_VAL, state=IDLE, busy=0, done=0. Reset mid-RUN aborts with no done pulse.
- States:
  - IDLE: count holds. start=1 -> RUN, busy=1 next cycle.
  - RUN: on each edge with cnt_en & borrow_in, count <= count-1, modulo 2^WIDTH (0 wraps to all-ones). If count==0 and a decrement occurs: wrap, then -> IDLE, done=1 for one cycle, busy=0.
- Load:
  - load=1 in any state: count <= load_val next edge. Load overrides decrement in the same cycle, and state does not change.
  - load & start together in IDLE: the value is loaded and the FSM enters RUN; the first decrement occurs on the following enabled edge.
- Other handshake cases:
  - start while already in RUN is ignored.
  - done is never asserted together with busy.
- Latency:
  - Decrement is visible on count one cycle after the enabled edge.
  - borrow_out has zero latency (combinational from registers and inputs).
  - Terminal count in RUN takes (loaded value + 1) enabled cycles before done.
- Boundary cases:
  - load_val=0 with start: one enabled cycle, then wrap and done.
  - cnt_en=0 freezes count and state; borrow_in=0 likewise freezes count.
- Only full WIDTH arithmetic is used; no saturation.

Optional Feature:
- Macro AUTO_RELOAD_EN.
- Defined:
  - Adds a WIDTH-bit reload register, written on every load.
  - At terminal count in RUN, count <= reload register instead of wrapping, the FSM stays in RUN, and done pulses every period.
  - Only rst or load changes the reload register; there is no stop other than rst.
- Undefined: behaviour as above (wrap, return to IDLE); no reload register is synthesized.

Decomposition:
- Package cm162_pkg: state enum (IDLE, RUN), WIDTH bounds constants, RESET_VAL default.
- One natural sub-module, cm162_dec_core: combinational next-count and zero-detect (count-1, count==0), reusable by an up/down variant.
- FSM and registers stay in the top module.

Test Plan:
- rst during RUN at count=5 -> next cycle count=0, busy=0, done=0, no done pulse.
- load_val=3, load+start, cnt_en=borrow_in=1 -> count 3,2,1,0, then wrap to 15 with done=1 one cycle, busy=0; 4 enabled edges after entering RUN.
- RUN at count=6, cnt_en toggling 1,0,1 -> count 6,5,5,4; borrow_out stays 0.
- count=0 in RUN with cnt_en=1, borrow_in=1 -> borrow_out=1 same cycle; two cascaded slices loaded 0x10 (upper=1, lower=0) reach 0x0F on the next edge.
- load=1 with load_val=9 while a decrement is enabled at count=4 -> count=9 (load wins), state remains RUN.
- AUTO_RELOAD_EN defined, load 2, start -> count 2,1,0,2,1,0; done pulses at each reload; busy stays 1.

Source files
------------

// File: rtl/cm162_pkg.sv
// ---------------------------------------------------------------------------
// cm162_pkg
// Shared definitions for the cm162 down-counter slice:
//   - state_e          : FSM state encoding (IDLE, RUN)
//   - CM162_WIDTH_MIN  : smallest supported counter width
//   - CM162_WIDTH_MAX  : largest supported counter width
//   - CM162_WIDTH_DEF  : default counter width
//   - CM162_RESET_DEF  : default count value after reset
// ---------------------------------------------------------------------------
package cm162_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int CM162_WIDTH_MIN = 32'sd2;
    localparam int CM162_WIDTH_MAX = 32'sd16;
    localparam int CM162_WIDTH_DEF = 32'sd4;
    localparam int CM162_RESET_DEF = 32'sd0;

endpackage : cm162_pkg

// File: rtl/cm162_dec_core.sv
// ---------------------------------------------------------------------------
// cm162_dec_core
// Combinational decrement and zero-detect for one counter slice.
// Kept separate so an up/down variant can share the same datapath.
// Ports:
//   count     in  WIDTH  current count
//   count_dec out WIDTH  count - 1, modulo 2^WIDTH (0 becomes all-ones)
//   is_zero   out 1      count == 0
// ---------------------------------------------------------------------------
module cm162_dec_core
    import cm162_pkg::*;
#(
    parameter int WIDTH = CM162_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_dec,
    output logic             is_zero
);

    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    // Full-width subtract; the natural modulo wrap is the intended behaviour
    assign count_dec = count - ONE_C;

    // Terminal-count detect
    assign is_zero = (count == ZERO_C);

endmodule : cm162_dec_core

// File: rtl/cm162_down_counter.sv
// ---------------------------------------------------------------------------
// cm162_down_counter
// Registered, cascadable down-counter slice with a start/busy/done handshake.
// A controller loads a value, pulses start, and waits for done. While RUN,
// the count decrements on each edge with cnt_en & borrow_in. At zero the
// next decrement wraps to all-ones, the FSM returns to IDLE and done pulses.
// Load always wins over decrement and never changes state, except that
// load together with start in IDLE also launches the countdown.
//
// Build option: define AUTO_RELOAD_EN to add a reload register (written on
// every load). At terminal count the slice reloads instead of wrapping,
// stays in RUN, and pulses done once per period; only rst stops it.
//
// Parameters:
//   WIDTH      counter width (2..16)
//   RESET_VAL  count value after reset
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   load       in   1      parallel load strobe
//   load_val   in   WIDTH  value captured on load
//   start      in   1      launch countdown (ignored while RUN)
//   cnt_en     in   1      global count enable
//   borrow_in  in   1      cascade enable from lower slice (tie 1 on lowest)
//   count      out  WIDTH  registered count
//   borrow_out out  1      combinational terminal borrow for the next slice
//   busy       out  1      registered, high while RUN
//   done       out  1      registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module cm162_down_counter
    import cm162_pkg::*;
#(
    parameter int WIDTH     = CM162_WIDTH_DEF,
    parameter int RESET_VAL = CM162_RESET_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             cnt_en,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] count,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] RESET_COUNT_C = WIDTH'(RESET_VAL);

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic [WIDTH-1:0] count_dec_s;
    logic             is_zero_s;
    logic             dec_en_s;
    logic             busy_r;
    logic             busy_next_s;
    logic             done_r;
    logic             done_next_s;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_r;
`endif

    cm162_dec_core #(
        .WIDTH (WIDTH)
    ) u_dec_core (
        .count     (count_r),
        .count_dec (count_dec_s),
        .is_zero   (is_zero_s)
    );

    // A decrement only happens in RUN with both the local and cascade enables
    assign dec_en_s   = (state_r == RUN) & cnt_en & borrow_in;
    assign borrow_out = dec_en_s & is_zero_s;

    assign count = count_r;
    assign busy  = busy_r;
    assign done  = done_r;

    // Next-state, next-count and done decode; load has priority over counting
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        done_next_s  = 1'b0;
        if (load) begin
            count_next_s = load_val;
            if ((state_r == IDLE) && start) begin
                state_next_s = RUN;
            end else begin
                state_next_s = state_r;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_next_s = RUN;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                RUN: begin
                    if (dec_en_s) begin
                        if (is_zero_s) begin
`ifdef AUTO_RELOAD_EN
                            count_next_s = reload_r;
                            state_next_s = RUN;
`else
                            count_next_s = count_dec_s;
                            state_next_s = IDLE;
`endif
                            done_next_s  = 1'b1;
                        end else begin
                            count_next_s = count_dec_s;
                        end
                    end else begin
                        count_next_s = count_r;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // busy mirrors the state the FSM is about to enter so it is registered
    assign busy_next_s = (state_next_s == RUN);

    // State, count and handshake flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= RESET_COUNT_C;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

`ifdef AUTO_RELOAD_EN
    // Reload register follows every load so the period tracks the last load
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_r <= RESET_COUNT_C;
        end else if (load) begin
            reload_r <= load_val;
        end else begin
            reload_r <= reload_r;
        end
    end
`endif

endmodule : cm162_down_counter
